// File: rtl/level_frame_tx.sv
// level_frame_tx: serial command-frame transmitter for the master-to-slave MMC link.
// Packs three phase level requests, the current signs, the frequency select and the
// gate-block bit into one idle-high UART-style frame:
//   start(0) | P[0]..P[14] (LSB first) | even parity over P | STOP_BITS x 1.
// Handshake: a command moves when in_valid && in_ready are both high at a rising clk edge.
// in_ready depends only on the FSM state, never on in_valid. A command with any level
// above 4 is dropped, and cmd_err pulses for one cycle.
module level_frame_tx #(
  parameter int CLKS_PER_BIT = 50,
  parameter int STOP_BITS    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] va_level,
  input  logic [2:0] vb_level,
  input  logic [2:0] vc_level,
  input  logic [2:0] sign_i,
  input  logic [1:0] sel,
  input  logic       sw_block,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       cmd_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  DATA_LAST = 4'd14;
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [3:0]  bit_idx, bit_n;
  logic [14:0] shreg, shreg_n;
  logic        parity, parity_n;
  logic        tx_q, tx_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  logic [14:0] payload;
  logic        levels_ok;
  logic        bit_end;

  assign payload   = {sw_block, sel, sign_i, vc_level, vb_level, va_level};
  assign levels_ok = (va_level <= 3'd4) && (vb_level <= 3'd4) && (vc_level <= 3'd4);
  assign bit_end   = (baud_cnt == BAUD_LAST);

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign tx         = tx_q;
  assign frame_done = done_q;
  assign cmd_err    = err_q;
  assign state_dbg  = state;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      parity   <= parity_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
      err_q    <= err_q ? 1'b0 : err_n;
    end
  end

  // Next-state logic: tx_n only changes when a bit period ends (or on accept).
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    parity_n = parity;
    tx_n     = tx_q;
    done_n   = 1'b0;
    err_n    = 1'b0;

    if (state != IDLE) begin
      baud_n = bit_end ? 16'd0 : baud_cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        tx_n   = 1'b1;
        if (in_valid) begin
          if (levels_ok) begin
            state_n  = START;
            shreg_n  = payload;
            parity_n = ^payload;
            tx_n     = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
          shreg_n = {1'b0, shreg[14:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == DATA_LAST) begin
            state_n = PARITY;
            bit_n   = '0;
            tx_n    = parity;
          end else begin
            bit_n   = bit_idx + 4'd1;
            tx_n    = shreg[0];
            shreg_n = {1'b0, shreg[14:1]};
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            state_n = IDLE;
            bit_n   = '0;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_level_frame_tx.sv
// Bench for level_frame_tx with CLKS_PER_BIT=4, STOP_BITS=2 (19 bits x 4 = 76 cycles/frame).
// A vector table holds each command and its hand-computed payload and parity, or marks
// the command as one that must be rejected. Hand-written sequences cover back-to-back
// frames, inputs changing mid-frame, and reset in the middle of a frame.
module tb_level_frame_tx;

  localparam int CPB = 4;
  localparam int NSB = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] va_level, vb_level, vc_level, sign_i;
  logic [1:0] sel;
  logic       sw_block, in_valid;
  logic       in_ready, tx, busy, frame_done, cmd_err;
  logic [2:0] state_dbg;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  va, vb, vc, sgn;
    logic [1:0]  sel;
    logic        sw;
    logic        rej;
    logic [14:0] p;
    logic        par;
  } vec_t;

  vec_t tab[8];

  level_frame_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(NSB)) dut (
    .clk(clk), .rst(rst),
    .va_level(va_level), .vb_level(vb_level), .vc_level(vc_level),
    .sign_i(sign_i), .sel(sel), .sw_block(sw_block),
    .in_valid(in_valid), .in_ready(in_ready),
    .tx(tx), .busy(busy), .frame_done(frame_done), .cmd_err(cmd_err),
    .state_dbg(state_dbg)
  );

  // Clock: 10 ns period; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  task automatic drive(input vec_t v);
    va_level = v.va; vb_level = v.vb; vc_level = v.vc;
    sign_i   = v.sgn; sel = v.sel; sw_block = v.sw;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Walk one frame that was accepted at the previous rising edge.
  // mode 0: drop in_valid in the first cycle; mode 1: present nxt with in_valid still high;
  // mode 2: drop in_valid, then present nxt fields in the middle of the data bits.
  task automatic run_frame(input string name, input logic [14:0] p, input logic par,
                           input int mode, input vec_t nxt);
    logic [18:0] bits;
    logic        ok;
    logic [3:0]  seen;
    int          idx;
    bits = {2'b11, par, p, 1'b0};
    for (int b = 0; b < 19; b++) begin
      ok   = 1'b1;
      seen = 4'h0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        idx = b * CPB + c;
        if (idx == 0) begin
          if (mode == 1) drive(nxt);
          else in_valid = 1'b0;
        end
        if (idx == 20 && mode == 2) drive(nxt);
        if (tx !== bits[b] || busy !== 1'b1 || in_ready !== 1'b0 || frame_done !== 1'b0) begin
          ok   = 1'b0;
          seen = {tx, busy, in_ready, frame_done};
        end
      end
      n_vec++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s bit%0d: {tx,busy,in_ready,frame_done}=%b expected {%b,1,0,0}",
                 name, b, seen, bits[b]);
      end
    end
    @(negedge clk);
    check({name, " done cycle"}, {4'h0, frame_done, in_ready, busy, tx}, 8'b0000_1101);
  endtask

  initial begin
    vec_t tmp;
    //          va    vb    vc    sgn     sel    sw    rej   p         par
    tab[0] = '{3'd4, 3'd2, 3'd0, 3'b101, 2'd2, 1'b0, 1'b0, 15'h2A14, 1'b1};
    tab[1] = '{3'd0, 3'd0, 3'd0, 3'b000, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0};
    tab[2] = '{3'd4, 3'd4, 3'd4, 3'b111, 2'd3, 1'b1, 1'b0, 15'h7F24, 1'b1};
    tab[3] = '{3'd1, 3'd3, 3'd2, 3'b010, 2'd1, 1'b0, 1'b0, 15'h1499, 1'b0};
    tab[4] = '{3'd3, 3'd0, 3'd1, 3'b000, 2'd0, 1'b1, 1'b0, 15'h4043, 1'b0};
    tab[5] = '{3'd5, 3'd0, 3'd0, 3'b000, 2'd0, 1'b0, 1'b1, 15'h0000, 1'b0};
    tab[6] = '{3'd0, 3'd7, 3'd0, 3'b111, 2'd3, 1'b1, 1'b1, 15'h0000, 1'b0};
    tab[7] = '{3'd1, 3'd1, 3'd6, 3'b001, 2'd1, 1'b0, 1'b1, 15'h0000, 1'b0};

    // Reset held for three cycles.
    rst = 1'b1; in_valid = 1'b0; drive(tab[1]);
    repeat (3) @(negedge clk);
    check("reset outputs", {3'b000, cmd_err, frame_done, in_ready, busy, tx}, 8'b0000_0101);
    check("reset state", {5'd0, state_dbg}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", {3'b000, cmd_err, frame_done, in_ready, busy, tx}, 8'b0000_0101);

    // Table: accepted commands produce full frames, out-of-range levels are rejected.
    for (int i = 0; i < 8; i++) begin
      drive(tab[i]);
      in_valid = 1'b1;
      if (tab[i].rej) begin
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("reject%0d", i), {4'h0, cmd_err, in_ready, busy, tx}, 8'b0000_1101);
        @(negedge clk);
        check($sformatf("reject%0d pulse end", i), {4'h0, cmd_err, in_ready, busy, tx},
              8'b0000_0101);
      end else begin
        run_frame($sformatf("vec%0d", i), tab[i].p, tab[i].par, 0, tab[i]);
        @(negedge clk);
        check($sformatf("vec%0d done pulse end", i), {7'd0, frame_done}, 8'd0);
      end
    end

    // Back-to-back: in_valid stays high, second start bit directly after frame_done.
    drive(tab[0]);
    in_valid = 1'b1;
    run_frame("b2b first", tab[0].p, tab[0].par, 1, tab[2]);
    run_frame("b2b second", tab[2].p, tab[2].par, 0, tab[2]);
    @(negedge clk);
    check("b2b idle", {6'd0, in_ready, tx}, 8'b0000_0011);

    // Inputs change during the data bits; frame keeps the latched command.
    tmp = tab[3];
    tmp.va = 3'd4;
    drive(tab[3]);
    in_valid = 1'b1;
    run_frame("latched", tab[3].p, tab[3].par, 2, tmp);
    @(negedge clk);

    // Reset during data bit 7, then a clean full frame.
    drive(tab[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (32) @(negedge clk);
    check("mid-frame bit7", {6'd0, busy, tx}, 8'b0000_0010);
    rst = 1'b1;
    @(negedge clk);
    check("reset mid-frame", {5'd0, in_ready, busy, tx}, 8'b0000_0101);
    rst = 1'b0;
    drive(tab[2]);
    in_valid = 1'b1;
    run_frame("after reset", tab[2].p, tab[2].par, 0, tab[2]);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
